wb_unit: RTL and testbench

- Write-back stage driving the register file's single write port (regW/we/BusW) and arbitrating two result sources.
- Single-cycle ALU results from the MEM/WB boundary.
- Late-returning load data from the data-memory interface, via valid/ready handshake.
- Buffers pending loads, resolves WAW against younger ALU writes, and gives decode forwarding and pending-hazard information for two source registers.

---
 rtl/wb_unit.sv | 135 +++++++++++++
 tb/tb_wb_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// Write-back stage: arbitrates single-cycle ALU results against buffered late
// load returns onto the register file's single write port, with WAW kill and forwarding.
module wb_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_stall,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  output logic [4:0]  o_regW,
  output logic        o_we,
  output logic [31:0] o_BusW,
  input  logic [4:0]  i_fwdA_reg,
  input  logic [4:0]  i_fwdB_reg,
  output logic        o_fwdA_hit,
  output logic [31:0] o_fwdA_data,
  output logic        o_fwdA_pend,
  output logic        o_fwdB_hit,
  output logic [31:0] o_fwdB_data,
  output logic        o_fwdB_pend
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0][4:0]  rd_q, rd_d;
  logic [DEPTH-1:0][31:0] data_q, data_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [4:0]             regw_q, regw_d;
  logic [31:0]            busw_q, busw_d;

  logic head_vld, full, alu_acc, push, pop, pop_wr;

  always_comb begin
    full        = (cnt_q == FULL_CNT);
    head_vld    = (|cnt_q) && vld_q[rd_ptr_q];
    o_ld_ready  = (cnt_q < FULL_CNT);
    o_alu_stall = full && head_vld;
    alu_acc     = i_alu_valid && !o_alu_stall;
    push        = i_ld_valid && o_ld_ready;
    pop_wr      = head_vld && !alu_acc;
    // Killed heads leave without consuming the write port.
    pop         = (|cnt_q) && (!vld_q[rd_ptr_q] || !alu_acc);
  end

  always_comb begin
    vld_d    = vld_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      rd_d[wr_ptr_q]   = i_ld_rd;
      data_d[wr_ptr_q] = i_ld_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    // Younger ALU write supersedes any older buffered load, including one landing now.
    if (alu_acc && (|i_alu_rd)) begin
      for (int e = 0; e < DEPTH; e++)
        if (rd_d[e] == i_alu_rd) vld_d[e] = 1'b0;
    end
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    we_d   = 1'b0;
    regw_d = regw_q;
    busw_d = busw_q;
    if (alu_acc) begin
      regw_d = i_alu_rd;
      busw_d = i_alu_data;
      we_d   = |i_alu_rd;
    end else if (pop_wr) begin
      regw_d = rd_q[rd_ptr_q];
      busw_d = data_q[rd_ptr_q];
      we_d   = |rd_q[rd_ptr_q];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q    <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      regw_q   <= '0;
      busw_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      regw_q   <= regw_d;
      busw_q   <= busw_d;
    end
  end

  assign o_we   = we_q;
  assign o_regW = regw_q;
  assign o_BusW = busw_q;

  always_comb begin
    o_fwdA_hit  = we_q && (regw_q == i_fwdA_reg) && (|i_fwdA_reg);
    o_fwdB_hit  = we_q && (regw_q == i_fwdB_reg) && (|i_fwdB_reg);
    o_fwdA_data = o_fwdA_hit ? busw_q : 32'h0;
    o_fwdB_data = o_fwdB_hit ? busw_q : 32'h0;
    o_fwdA_pend = 1'b0;
    o_fwdB_pend = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (vld_q[e] && (rd_q[e] == i_fwdA_reg) && (|i_fwdA_reg)) o_fwdA_pend = 1'b1;
      if (vld_q[e] && (rd_q[e] == i_fwdB_reg) && (|i_fwdB_reg)) o_fwdB_pend = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: expected register writes are queued as stimulus is driven
// and popped by a monitor whenever the write port fires.
module tb_wb_unit;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_alu_valid = 1'b0, i_ld_valid = 1'b0;
  logic [4:0]  i_alu_rd = '0, i_ld_rd = '0, i_fwdA_reg = '0, i_fwdB_reg = '0;
  logic [31:0] i_alu_data = '0, i_ld_data = '0;
  logic        o_alu_stall, o_ld_ready, o_we;
  logic [4:0]  o_regW;
  logic [31:0] o_BusW, o_fwdA_data, o_fwdB_data;
  logic        o_fwdA_hit, o_fwdA_pend, o_fwdB_hit, o_fwdB_pend;

  int vectors = 0, miscompares = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  wb_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .o_alu_stall(o_alu_stall),
    .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_ld_ready(o_ld_ready),
    .o_regW(o_regW), .o_we(o_we), .o_BusW(o_BusW),
    .i_fwdA_reg(i_fwdA_reg), .i_fwdB_reg(i_fwdB_reg),
    .o_fwdA_hit(o_fwdA_hit), .o_fwdA_data(o_fwdA_data), .o_fwdA_pend(o_fwdA_pend),
    .o_fwdB_hit(o_fwdB_hit), .o_fwdB_data(o_fwdB_data), .o_fwdB_pend(o_fwdB_pend)
  );

  always #5 i_clk = ~i_clk;

  // Write-port monitor: every committed write must match the oldest expectation.
  always @(posedge i_clk) begin
    #1;
    if (i_rst_n && o_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write got r%0d=%h required none", o_regW, o_BusW);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_regW, o_BusW} !== mon_e) begin
          miscompares++;
          $display("FAIL write_order got r%0d=%h required r%0d=%h", o_regW, o_BusW, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle();
    i_alu_valid = 1'b0;
    i_ld_valid  = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    i_alu_valid = 1'b1; i_alu_rd = rd; i_alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    i_ld_valid = 1'b1; i_ld_rd = rd; i_ld_data = d;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    alu(5'd5, 32'hDEAD); ld(5'd6, 32'hBEEF);
    @(negedge i_clk); @(negedge i_clk); #1;
    vectors++;
    if ({o_we, o_regW, o_BusW} !== 38'h0) begin
      miscompares++; $display("FAIL reset_wport got we=%b r%0d=%h required 0", o_we, o_regW, o_BusW);
    end
    vectors++;
    if ({o_ld_ready, o_alu_stall} !== 2'b10) begin
      miscompares++; $display("FAIL reset_flow got ready=%b stall=%b required 1/0", o_ld_ready, o_alu_stall);
    end
    @(negedge i_clk);
    i_ld_valid = 1'b0;
    i_rst_n = 1'b1;
    alu(5'd5, 32'h1234); exp_q.push_back({5'd5, 32'h1234});
    @(negedge i_clk); idle(); #1;
    vectors++;
    if ({o_we, o_regW} !== {1'b1, 5'd5}) begin
      miscompares++; $display("FAIL first_write got we=%b r%0d required we=1 r5", o_we, o_regW);
    end
    @(negedge i_clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL reset_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_arbitration();
    @(negedge i_clk);
    i_fwdA_reg = 5'd7;
    alu(5'd3, 32'h3333); ld(5'd7, 32'hAAAA);
    exp_q.push_back({5'd3, 32'h3333}); exp_q.push_back({5'd7, 32'hAAAA});
    #1;
    vectors++;
    if ({o_ld_ready, o_alu_stall, o_fwdA_pend} !== 3'b100) begin
      miscompares++; $display("FAIL arb_pre got rdy/stall/pend=%b%b%b required 100", o_ld_ready, o_alu_stall, o_fwdA_pend);
    end
    @(negedge i_clk); idle(); #1;
    vectors++;
    if ({o_fwdA_pend, o_fwdA_hit} !== 2'b10) begin
      miscompares++; $display("FAIL arb_pend got pend=%b hit=%b required 1/0", o_fwdA_pend, o_fwdA_hit);
    end
    @(negedge i_clk); #1;
    vectors++;
    if ({o_fwdA_pend, o_fwdA_hit, o_fwdA_data} !== {2'b01, 32'hAAAA}) begin
      miscompares++; $display("FAIL arb_drain_fwd got pend=%b hit=%b data=%h required 0/1/aaaa", o_fwdA_pend, o_fwdA_hit, o_fwdA_data);
    end
    @(negedge i_clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL arb_done got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_full_stall();
    @(negedge i_clk);
    alu(5'd4, 32'h40); ld(5'd8, 32'h8888); exp_q.push_back({5'd4, 32'h40});
    @(negedge i_clk);
    alu(5'd4, 32'h41); ld(5'd9, 32'h9999); exp_q.push_back({5'd4, 32'h41});
    #1;
    vectors++;
    if ({o_ld_ready, o_alu_stall} !== 2'b10) begin
      miscompares++; $display("FAIL full_one got ready=%b stall=%b required 1/0", o_ld_ready, o_alu_stall);
    end
    @(negedge i_clk);
    i_ld_valid = 1'b0; alu(5'd4, 32'h42); exp_q.push_back({5'd8, 32'h8888});
    #1;
    vectors++;
    if ({o_ld_ready, o_alu_stall} !== 2'b01) begin
      miscompares++; $display("FAIL full_stall got ready=%b stall=%b required 0/1", o_ld_ready, o_alu_stall);
    end
    @(negedge i_clk);
    exp_q.push_back({5'd4, 32'h42});
    #1;
    vectors++;
    if ({o_ld_ready, o_alu_stall} !== 2'b10) begin
      miscompares++; $display("FAIL full_release got ready=%b stall=%b required 1/0", o_ld_ready, o_alu_stall);
    end
    @(negedge i_clk); idle(); exp_q.push_back({5'd9, 32'h9999});
    @(negedge i_clk); @(negedge i_clk); #1;
    vectors++;
    if (exp_q.size() != 0 || o_ld_ready !== 1'b1) begin
      miscompares++; $display("FAIL full_done got %0d pending ready=%b required 0/1", exp_q.size(), o_ld_ready);
    end
  endtask

  task automatic test_waw_kill();
    @(negedge i_clk);
    i_fwdA_reg = 5'd10; ld(5'd10, 32'h1111);
    @(negedge i_clk);
    i_ld_valid = 1'b0; alu(5'd10, 32'h2222); exp_q.push_back({5'd10, 32'h2222});
    #1;
    vectors++;
    if (o_fwdA_pend !== 1'b1) begin
      miscompares++; $display("FAIL waw_pend_before got %b required 1", o_fwdA_pend);
    end
    @(negedge i_clk); idle(); #1;
    vectors++;
    if ({o_fwdA_pend, o_fwdA_hit, o_fwdA_data} !== {2'b01, 32'h2222}) begin
      miscompares++; $display("FAIL waw_after got pend=%b hit=%b data=%h required 0/1/2222", o_fwdA_pend, o_fwdA_hit, o_fwdA_data);
    end
    @(negedge i_clk); #1;
    vectors++;
    if (o_we !== 1'b0) begin
      miscompares++; $display("FAIL waw_killed_pop got we=%b r%0d required we=0", o_we, o_regW);
    end
    // Same-cycle push and younger ALU write to the same register.
    i_fwdA_reg = 5'd12;
    alu(5'd12, 32'hC); ld(5'd12, 32'hD); exp_q.push_back({5'd12, 32'hC});
    @(negedge i_clk); idle(); #1;
    vectors++;
    if (o_fwdA_pend !== 1'b0) begin
      miscompares++; $display("FAIL waw_same_cycle got pend=%b required 0", o_fwdA_pend);
    end
    @(negedge i_clk); @(negedge i_clk); #1;
    vectors++;
    if (exp_q.size() != 0 || o_we !== 1'b0) begin
      miscompares++; $display("FAIL waw_done got %0d pending we=%b required 0/0", exp_q.size(), o_we);
    end
  endtask

  task automatic test_r0();
    @(negedge i_clk);
    i_fwdA_reg = 5'd0; i_fwdB_reg = 5'd0;
    alu(5'd0, 32'hFFFF); ld(5'd0, 32'h5);
    @(negedge i_clk); idle(); #1;
    vectors++;
    if ({o_we, o_regW, o_BusW} !== {1'b0, 5'd0, 32'hFFFF}) begin
      miscompares++; $display("FAIL r0_alu got we=%b r%0d=%h required we=0 r0=ffff", o_we, o_regW, o_BusW);
    end
    vectors++;
    if ({o_fwdA_hit, o_fwdA_pend, o_fwdB_hit, o_fwdB_pend} !== 4'b0) begin
      miscompares++; $display("FAIL r0_fwd got %b%b%b%b required 0000", o_fwdA_hit, o_fwdA_pend, o_fwdB_hit, o_fwdB_pend);
    end
    @(negedge i_clk); #1;
    vectors++;
    if ({o_we, o_BusW} !== {1'b0, 32'h5}) begin
      miscompares++; $display("FAIL r0_load got we=%b data=%h required we=0 data=5", o_we, o_BusW);
    end
    @(negedge i_clk); #1;
    vectors++;
    if (exp_q.size() != 0 || o_ld_ready !== 1'b1) begin
      miscompares++; $display("FAIL r0_done got %0d pending ready=%b required 0/1", exp_q.size(), o_ld_ready);
    end
  endtask

  task automatic test_wrap_forward();
    int i = 1;
    int n = 0;
    int hits = 0;
    logic acc;
    while (n < 40 && (i <= 5 || exp_q.size() != 0)) begin
      @(negedge i_clk);
      n++;
      i_fwdB_reg = (o_regW != 5'd0) ? o_regW : 5'd1;
      if (i <= 5) ld(5'(i), 32'h100 + 32'(i)); else idle();
      #1;
      acc = (i <= 5) && o_ld_ready;
      if (acc) exp_q.push_back({5'(i), 32'h100 + 32'(i)});
      if (o_we === 1'b1) begin
        hits++;
        vectors++;
        if ({o_fwdB_hit, o_fwdB_data} !== {1'b1, o_BusW}) begin
          miscompares++; $display("FAIL wrap_fwdB got hit=%b data=%h required 1/%h", o_fwdB_hit, o_fwdB_data, o_BusW);
        end
      end
      @(posedge i_clk);
      if (acc) i++;
    end
    @(negedge i_clk); idle(); #1;
    vectors++;
    if (i != 6 || exp_q.size() != 0 || hits < 4) begin
      miscompares++; $display("FAIL wrap_done got issued=%0d pending=%0d hits=%0d required 5/0/>=4", i - 1, exp_q.size(), hits);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_full_stall();
    test_waw_kill();
    test_r0();
    test_wrap_forward();
    repeat (3) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
